freq_meter: RTL and testbench

- Measures the frequency of an asynchronous user-generated signal (e.g. a slow clock from the divider blocks) against the 100 MHz board clock.
- Counts rising edges of the input over a fixed gate window (1 s by default) and publishes the count as frequency in Hz, with a one-cycle valid strobe.
- Runs back-to-back measurements while enabled. Feeds the display/readout path of the counter design.

---
 rtl/freq_meter_pkg.sv | 21 ++
 rtl/sync_edge_det.sv | 28 ++
 rtl/freq_meter.sv | 119 +++++++++++
 tb/tb_freq_meter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter: FSM state encoding,
// default clock/width constants and the timer width helper.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam int unsigned CLK_HZ_DEF = 100000000;
    localparam int          CNT_W_DEF  = 28;

    // Bits needed to hold 0..n-1; never below 1 so a 1-cycle gate still elaborates.
    function automatic int timer_w(input int unsigned n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input plus a history flop;
// emits a one-cycle pulse on each synchronized rising edge.
module sync_edge_det (
    input  logic clk_in,
    input  logic rst,
    input  logic async_in,
    output logic rise_out
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= async_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign rise_out = r_s2 & ~r_s3;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronized rising edges of sig_in over a fixed
// window of GATE_CYCLES clocks and publishes the count with a valid strobe.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned CLK_HZ      = CLK_HZ_DEF,
    parameter int unsigned GATE_CYCLES = CLK_HZ,
    parameter int          CNT_W       = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             valid,
    output logic             ovf,
    output logic             busy
);

    localparam int               TW      = timer_w(GATE_CYCLES);
    localparam logic [TW-1:0]    T_LAST  = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    logic [TW-1:0]    r_timer;
    logic [CNT_W-1:0] r_edge_cnt;
    logic             r_sat;
    logic [CNT_W-1:0] r_freq;
    logic             r_valid;
    logic             r_ovf;
    logic             r_busy;

    logic             w_rise;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_sat_next;

    sync_edge_det u_sync (
        .clk_in   (clk_in),
        .rst      (rst),
        .async_in (sig_in),
        .rise_out (w_rise)
    );

    // Count including this cycle's edge, so the final gate cycle's rise is published.
    always_comb begin
        w_cnt_next = r_edge_cnt;
        w_sat_next = r_sat;
        if (w_rise) begin
            if (r_edge_cnt == CNT_MAX) w_sat_next = 1'b1;
            else                       w_cnt_next = r_edge_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
            r_freq     <= '0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    if (en) begin
                        r_state    <= GATE;
                        r_timer    <= '0;
                        r_edge_cnt <= '0;
                        r_sat      <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                GATE: begin
                    if (!en) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_timer == T_LAST) begin
                        // Outputs are registered, so they land during the LATCH cycle.
                        r_state <= LATCH;
                        r_busy  <= 1'b0;
                        r_freq  <= w_cnt_next;
                        r_ovf   <= w_sat_next;
                        r_valid <= 1'b1;
                    end else begin
                        r_timer    <= r_timer + 1'b1;
                        r_edge_cnt <= w_cnt_next;
                        r_sat      <= w_sat_next;
                    end
                end
                LATCH: begin
                    r_timer    <= '0;
                    r_edge_cnt <= '0;
                    r_sat      <= 1'b0;
                    if (en) begin
                        r_state <= GATE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign freq  = r_freq;
    assign valid = r_valid;
    assign ovf   = r_ovf;
    assign busy  = r_busy;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with a 100-cycle gate: normal, held, max-rate,
// saturating (4-bit instance), abort and mid-gate reset scenarios.
module tb_freq_meter;
    import freq_meter_pkg::*;

    logic        clk;
    logic        rst;
    logic        en;
    logic        en4;
    logic        sig_in;
    logic [27:0] freq;
    logic        valid;
    logic        ovf;
    logic        busy;
    logic [3:0]  freq4;
    logic        valid4;
    logic        ovf4;
    logic        busy4;

    int tests = 0;
    int fails = 0;

    freq_meter #(.GATE_CYCLES(100), .CNT_W(28)) dut (
        .clk_in (clk), .rst (rst), .en (en), .sig_in (sig_in),
        .freq (freq), .valid (valid), .ovf (ovf), .busy (busy)
    );

    freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) dut4 (
        .clk_in (clk), .rst (rst), .en (en4), .sig_in (sig_in),
        .freq (freq4), .valid (valid4), .ovf (ovf4), .busy (busy4)
    );

    // clock / reset-free wave generator
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   per  = 0;
    logic hold = 1'b0;
    int   ph   = 0;

    initial begin
        sig_in = 1'b0;
        forever begin
            @(negedge clk);
            if (per == 0) begin
                sig_in = hold;
            end else begin
                ph     = (ph + 1) % per;
                sig_in = (ph < per / 2);
            end
        end
    end

    // selects which instance run_gate observes
    logic        sel = 1'b0;
    logic [31:0] m_freq;
    logic        m_valid;
    logic        m_ovf;
    logic        m_busy;
    assign m_freq  = sel ? 32'(freq4) : 32'(freq);
    assign m_valid = sel ? valid4 : valid;
    assign m_ovf   = sel ? ovf4 : ovf;
    assign m_busy  = sel ? busy4 : busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Follows one gate from its first busy cycle (cycle 1) to the valid pulse,
    // which must land on cycle 101 after exactly 100 busy cycles.
    task automatic run_gate(input string tag, input int exp_f, input logic exp_o);
        int n;
        int hi;
        n = 0;
        while (!m_busy && n < 20) begin
            step(1);
            n++;
        end
        chk({tag, "_open"}, 32'(m_busy), 32'd1);
        n  = 0;
        hi = 0;
        while (!m_valid && n < 300) begin
            if (m_busy) hi++;
            step(1);
            n++;
        end
        chk({tag, "_valid"},  32'(m_valid), 32'd1);
        chk({tag, "_latency"}, 32'(n + 1), 32'd101);
        chk({tag, "_busy_len"}, 32'(hi), 32'd100);
        chk({tag, "_busy_latch"}, 32'(m_busy), 32'd0);
        chk({tag, "_freq"}, m_freq, 32'(exp_f));
        chk({tag, "_ovf"}, 32'(m_ovf), 32'(exp_o));
        step(1);
        chk({tag, "_pulse"}, 32'(m_valid), 32'd0);
    endtask

    initial begin
        int seen;
        rst  = 1'b1;
        en   = 1'b0;
        en4  = 1'b0;
        hold = 1'b1;
        step(3);
        chk("rst_freq",  32'(freq),  32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ovf",   32'(ovf),   32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_state", 32'(dut.r_state), 32'(IDLE));
        chk("rst_busy4", 32'(busy4), 32'd0);
        rst = 1'b0;
        step(5);

        // sig_in held high since before enable: no edges
        en = 1'b1;
        run_gate("held_a", 0, 1'b0);
        run_gate("held_b", 0, 1'b0);

        // period-10 square wave, back-to-back gates
        en = 1'b0;
        step(1);
        chk("dis_busy", 32'(busy), 32'd0);
        per = 10;
        step(20);
        en = 1'b1;
        run_gate("p10_a", 10, 1'b0);
        run_gate("p10_b", 10, 1'b0);
        run_gate("p10_c", 10, 1'b0);

        // now at the timer==0 cycle of a fresh gate; abort at timer==50
        step(50);
        en = 1'b0;
        step(1);
        chk("abort_busy",  32'(busy),  32'd0);
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_freq",  32'(freq),  32'd10);
        chk("abort_state", 32'(dut.r_state), 32'(IDLE));
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (valid) seen++;
            step(1);
        end
        chk("abort_novalid", 32'(seen), 32'd0);
        en = 1'b1;
        run_gate("reen", 10, 1'b0);

        // reset at timer==70
        step(70);
        rst = 1'b1;
        step(1);
        chk("mid_rst_freq",  32'(freq),  32'd0);
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_ovf",   32'(ovf),   32'd0);
        chk("mid_rst_busy",  32'(busy),  32'd0);
        chk("mid_rst_state", 32'(dut.r_state), 32'(IDLE));
        rst = 1'b0;
        run_gate("post_rst", 10, 1'b0);

        // max rate: toggle every cycle
        en = 1'b0;
        per = 2;
        step(10);
        en = 1'b1;
        run_gate("p2", 50, 1'b0);
        en = 1'b0;

        // 4-bit instance: 25 edges saturate to 15
        per = 4;
        step(10);
        sel = 1'b1;
        en4 = 1'b1;
        run_gate("sat", 15, 1'b1);
        en4 = 1'b0;
        step(1);
        per = 10;
        step(20);
        chk("sat_hold_freq", 32'(freq4), 32'd15);
        chk("sat_hold_ovf",  32'(ovf4),  32'd1);
        en4 = 1'b1;
        run_gate("unsat", 10, 1'b0);
        en4 = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
